// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and arbiter states
// for the shared ALU arbiter.
package alu_pkg;

  localparam int NUM_SIZE = 32;
  localparam int CMD_SIZE_LOG2 = 3;
  localparam int CMD_W = 2 ** CMD_SIZE_LOG2;

  typedef enum logic [CMD_W-1:0] {
    NOOP = CMD_W'(0),
    ADD  = CMD_W'(1)
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_e;

  function automatic logic is_legal_cmd(
    input logic [CMD_W-1:0] cmd
  );
    return (cmd == NOOP) || (cmd == ADD);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker,
// first requester at or after ptr wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Scan downwards so the closest index to ptr is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between
// NUM_REQ requesters, one op in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*NUM_SIZE-1:0]  req_in1,
  input  logic [NUM_REQ*NUM_SIZE-1:0]  req_in2,
  input  logic [NUM_REQ*CMD_W-1:0]     req_cmd,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic signed [NUM_SIZE-1:0]   rsp_data,
  output logic                         rsp_err,
  output logic                         alu_enable,
  output logic                         alu_reset,
  output logic signed [NUM_SIZE-1:0]   alu_in1,
  output logic signed [NUM_SIZE-1:0]   alu_in2,
  output logic [CMD_W-1:0]             alu_cmd,
  input  logic signed [NUM_SIZE-1:0]   alu_out,
  output logic                         busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic                 err_q;

  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        win;
  logic                 any;
  logic [CMD_W-1:0]     win_cmd;
  logic                 hs;
  logic                 legal;
  logic                 init_act;
  logic                 done;
  logic [IW-1:0]        nxt_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  always_comb begin
    win_cmd  = req_cmd[win*CMD_W +: CMD_W];
    legal    = is_legal_cmd(win_cmd);
    hs       = (state == ST_IDLE) && any;
    // Quiet the INIT strobes while reset is still held.
    init_act = (state == ST_INIT) && reset;
    done     = (state == ST_RESP) && rsp_ready[owner];
    nxt_ptr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end

  always_comb begin
    req_ready  = '0;
    alu_in1    = '0;
    alu_in2    = '0;
    alu_cmd    = NOOP;
    alu_enable = 1'b0;
    alu_reset  = 1'b0;
    unique case (1'b1)
      init_act: begin
        alu_enable = 1'b1;
        alu_reset  = 1'b1;
      end
      hs: begin
        req_ready  = gnt;
        alu_in1    = req_in1[win*NUM_SIZE +: NUM_SIZE];
        alu_in2    = req_in2[win*NUM_SIZE +: NUM_SIZE];
        alu_cmd    = win_cmd;
        alu_enable = legal;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) rsp_valid[owner] = 1'b1;
    rsp_data = ((state == ST_RESP) && !err_q) ? alu_out : '0;
    rsp_err  = (state == ST_RESP) && err_q;
    busy     = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_INIT;
      rr_ptr <= '0;
      owner  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (hs) begin
            owner <= win;
            if (legal) begin
              state <= ST_EXEC;
            end else begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_EXEC: state <= ST_RESP;
        ST_RESP: begin
          if (done) begin
            rr_ptr <= nxt_ptr;
            err_q  <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus, transaction model
// and per-cycle compare for alu_arbiter.
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int NS = 32;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*NS-1:0]      req_in1 = '0;
  logic [N*NS-1:0]      req_in2 = '0;
  logic [N*CW-1:0]      req_cmd = '0;
  logic [N-1:0]         rsp_valid;
  logic [N-1:0]         rsp_ready = '0;
  logic signed [NS-1:0] rsp_data;
  logic                 rsp_err;
  logic                 alu_enable;
  logic                 alu_reset;
  logic signed [NS-1:0] alu_in1;
  logic signed [NS-1:0] alu_in2;
  logic [CW-1:0]        alu_cmd;
  logic signed [NS-1:0] alu_out;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_cmd    (req_cmd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_enable (alu_enable),
    .alu_reset  (alu_reset),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_cmd    (alu_cmd),
    .alu_out    (alu_out),
    .busy       (busy)
  );

  // The shared ALU: registered, enable-gated, sync reset; NOOP holds.
  always_ff @(posedge clk) begin
    if (alu_reset) alu_out <= '0;
    else if (alu_enable && alu_cmd == 8'd1) alu_out <= alu_in1 + alu_in2;
  end

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  int          m_ptr, m_owner, m_wait, m_w;
  bit          m_init, m_resp, m_err;
  logic [31:0] m_alu;
  logic [7:0]  m_c;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always_comb m_w = pick(req_valid, m_ptr);
  always_comb m_c = (m_w >= 0) ? req_cmd[m_w*CW +: CW] : 8'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_init <= 1'b1; m_resp <= 1'b0; m_wait <= 0;
      m_ptr <= 0; m_owner <= 0; m_err <= 1'b0;
    end else if (m_init) begin
      m_init <= 1'b0;
      m_alu  <= '0;
    end else if (m_resp) begin
      if (rsp_ready[m_owner]) begin
        m_resp <= 1'b0;
        m_ptr  <= (m_owner + 1) % N;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_resp <= 1'b1;
    end else if (m_w >= 0) begin
      m_owner <= m_w;
      if (m_c == 8'd1)
        m_alu <= req_in1[m_w*NS +: NS] + req_in2[m_w*NS +: NS];
      if (m_c <= 8'd1) begin
        m_err <= 1'b0; m_wait <= 1;
      end else begin
        m_err <= 1'b1; m_resp <= 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          c_idle;
  logic [7:0]  c_cmd;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_en", alu_enable, 0);
      chk("rst_alu_rst", alu_reset, 0);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_alu_in2", alu_in2, 0);
      chk("rst_alu_cmd", alu_cmd, 0);
      chk("rst_busy", busy, 1);
    end else if (m_init) begin
      chk("init_alu_en", alu_enable, 1);
      chk("init_alu_rst", alu_reset, 1);
      chk("init_busy", busy, 1);
      chk("init_req_ready", req_ready, 0);
      chk("init_rsp_valid", rsp_valid, 0);
    end else begin
      c_idle = !m_resp && (m_wait == 0);
      chk("busy", busy, !c_idle);
      chk("alu_rst", alu_reset, 0);
      if (c_idle && m_w >= 0) begin
        c_cmd = req_cmd[m_w*CW +: CW];
        chk("req_ready", req_ready, 32'(1 << m_w));
        chk("alu_in1", alu_in1, req_in1[m_w*NS +: NS]);
        chk("alu_in2", alu_in2, req_in2[m_w*NS +: NS]);
        chk("alu_cmd", alu_cmd, c_cmd);
        chk("alu_en_hs", alu_enable, c_cmd <= 8'd1);
      end else begin
        chk("req_ready", req_ready, 0);
        chk("alu_en", alu_enable, 0);
      end
      chk("rsp_valid", rsp_valid, m_resp ? 32'(1 << m_owner) : 0);
      chk("rsp_data", rsp_data, (m_resp && !m_err) ? m_alu : 0);
      chk("rsp_err", rsp_err, m_resp && m_err);
    end
  end

  // ---------------- transaction logs ----------------
  int          gq[$], gc[$], rq[$], rc[$];
  logic [31:0] rd[$];
  bit          re[$];
  int          en_cnt = 0;
  int          init_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          gq.push_back(i); gc.push_back(cyc);
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          rq.push_back(i); rc.push_back(cyc);
          rd.push_back(rsp_data); re.push_back(rsp_err);
        end
      end
      if (alu_enable) en_cnt++;
      if (alu_reset) init_cnt++;
    end
  end

  task automatic clear_logs();
    gq.delete(); gc.delete(); rq.delete();
    rc.delete(); rd.delete(); re.delete();
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [7:0] c);
    req_in1[i*NS +: NS] = a;
    req_in2[i*NS +: NS] = b;
    req_cmd[i*CW +: CW] = c;
  endtask

  task automatic wait_grant(input int i);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = req_valid[i] && req_ready[i];
    end
    chk($sformatf("grant_seen%0d", i), ok, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = rsp_valid[i];
    end
    chk($sformatf("rsp_seen%0d", i), ok, 1);
  endtask

  task automatic issue(input int i, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] c);
    set_op(i, a, b, c);
    req_valid[i] = 1'b1;
    wait_grant(i);
    wait_rsp(i);
    @(posedge clk); #1;
  endtask

  int exp_g[5] = '{0, 1, 2, 3, 0};
  int exp_d[5] = '{11, 112, 213, 314, 11};
  int e0;
  bit ok;

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("init_cycles", init_cnt, 1);
    chk("idle_busy", busy, 0);
    chk("idle_ready", req_ready, 0);

    // Contention: everyone asks at once, rotation from 0.
    clear_logs();
    for (int i = 0; i < N; i++) set_op(i, 100 * i + 1, i + 10, 8'd1);
    rsp_ready = '1;
    req_valid = '1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(posedge clk); #1;
      ok = (gq.size() >= 5);
    end
    chk("cont_grants", ok, 1);
    req_valid = '0;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clk); #1;
      ok = (rq.size() >= 5);
    end
    chk("cont_rsps", ok, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("cont_order%0d", k), gq[k], exp_g[k]);
      chk($sformatf("cont_data%0d", k), rd[k], exp_d[k]);
      chk($sformatf("cont_lat%0d", k), rc[k] - gc[k], 2);
    end

    // Single ADD with a negative operand.
    clear_logs();
    issue(0, 32'd5, 32'hFFFF_FFF9, 8'd1);
    chk("add_owner", rq[0], 0);
    chk("add_data", rd[0], 32'hFFFF_FFFE);
    chk("add_err", re[0], 0);
    chk("add_lat", rc[0] - gc[0], 2);

    // Backpressure on requester 2 while 0 waits.
    clear_logs();
    set_op(2, 32'h7FFF_FFFF, 32'd1, 8'd1);
    set_op(0, 32'd1, 32'd1, 8'd1);
    rsp_ready = 4'b1011;
    req_valid = 4'b0101;
    wait_grant(2);
    wait_rsp(2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 4'b0100);
      chk("bp_data", rsp_data, 32'h8000_0000);
      chk("bp_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    wait_grant(0);
    wait_rsp(0);
    @(posedge clk); #1;
    chk("bp_g0", gq[0], 2);
    chk("bp_g1", gq[1], 0);
    chk("bp_d0", rd[0], 32'h8000_0000);
    chk("bp_d1", rd[1], 2);

    // Illegal opcode never touches the ALU.
    clear_logs();
    e0 = en_cnt;
    issue(1, 32'd9, 32'd9, 8'h05);
    chk("ill_err", re[0], 1);
    chk("ill_data", rd[0], 0);
    chk("ill_lat", rc[0] - gc[0], 1);
    chk("ill_no_en", en_cnt - e0, 0);

    // NOOP reads back the previous result.
    clear_logs();
    issue(3, 32'd3, 32'd4, 8'd1);
    issue(3, 32'd0, 32'd0, 8'd0);
    chk("noop_add", rd[0], 7);
    chk("noop_data", rd[1], 7);
    chk("noop_err", re[1], 0);

    // Reset in EXEC drops the op and clears the ALU.
    clear_logs();
    set_op(0, 32'd10, 32'd20, 8'd1);
    req_valid[0] = 1'b1;
    wait_grant(0);
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_alu_en", alu_enable, 0);
    chk("mid_req_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_stale", rq.size(), 0);
    chk("mid_init_cycles", init_cnt, 2);
    issue(0, 32'd0, 32'd0, 8'd0);
    issue(0, 32'd10, 32'd20, 8'd1);
    chk("mid_noop", rd[0], 0);
    chk("mid_add", rd[1], 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
